// File: rtl/mem_rmw_merge_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_rmw_merge_if
// Purpose  : Bundles the masked-write, host-read and memory R0/W0 buses
//            between mem_rmw_merge and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_rmw_merge_if #(
  parameter int WIDTH  = 64,
  parameter int GRAN   = 8,
  parameter int ADDR_W = 6,
  parameter int MASK_W = WIDTH / GRAN
);
  // masked write request
  logic              wreq_valid;
  logic              wreq_ready;
  logic [ADDR_W-1:0] wreq_addr;
  logic [WIDTH-1:0]  wreq_data;
  logic [MASK_W-1:0] wreq_mask;
  // host read request / response
  logic              rreq_valid;
  logic              rreq_ready;
  logic [ADDR_W-1:0] rreq_addr;
  logic              rresp_valid;
  logic [WIDTH-1:0]  rresp_data;
  // memory read port
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [WIDTH-1:0]  R0_data;
  // memory write port
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [WIDTH-1:0]  W0_data;

  // Environment side: requesters plus the memory wrapper returning R0_data.
  modport master (
    output wreq_valid, wreq_addr, wreq_data, wreq_mask,
    output rreq_valid, rreq_addr,
    output R0_data,
    input  wreq_ready, rreq_ready, rresp_valid, rresp_data,
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data
  );

  // Merge block side.
  modport slave (
    input  wreq_valid, wreq_addr, wreq_data, wreq_mask,
    input  rreq_valid, rreq_addr,
    input  R0_data,
    output wreq_ready, rreq_ready, rresp_valid, rresp_data,
    output R0_addr, R0_en, W0_addr, W0_en, W0_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_rmw_merge.sv
`default_nettype none
// ============================================================================
// Module   : mem_rmw_merge
// Purpose  : Byte-masked write front end for a 1R1W memory with a single
//            full-word write enable. Full-mask writes go straight through,
//            zero-mask writes are absorbed, partial-mask writes become a
//            read-modify-write. Host reads share the read port, with a
//            same-cycle bypass from a colliding full-mask write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_rmw_merge #(
  parameter int DEPTH  = 48,
  parameter int WIDTH  = 64,
  parameter int GRAN   = 8,
  parameter int ADDR_W = 6,
  parameter int MASK_W = WIDTH / GRAN
) (
  input logic             clk,
  input logic             rst_n,
  mem_rmw_merge_if.slave  bus
);

  // Elaboration-time sanity checks on the parameter set.
  if (ADDR_W < $clog2(DEPTH)) begin : g_chk_addr_w
    $error("mem_rmw_merge: ADDR_W too narrow for DEPTH");
  end
  if (MASK_W * GRAN != WIDTH) begin : g_chk_gran
    $error("mem_rmw_merge: WIDTH must equal MASK_W*GRAN");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              rresp_valid_q, rresp_valid_d;
  logic              byp_q, byp_d;
  logic [WIDTH-1:0]  byp_data_q, byp_data_d;

  logic              mask_full, mask_zero, mask_part;
  logic              in_idle, in_rmw;
  logic              wreq_ready, rreq_ready;
  logic              wr_acc, rd_acc;
  logic [WIDTH-1:0]  bitmask;
  logic [WIDTH-1:0]  merged;
  logic              r0_en, w0_en;
  logic [ADDR_W-1:0] r0_addr, w0_addr;
  logic [WIDTH-1:0]  w0_data;

  // Expand the latched granule mask to a per-bit mask.
  for (genvar i = 0; i < MASK_W; i++) begin : g_bitmask
    assign bitmask[i*GRAN +: GRAN] = {GRAN{mask_q[i]}};
  end

  // Classify the incoming mask and resolve handshakes; all gated by reset
  // so nothing is accepted or issued while rst_n is low.
  always_comb begin
    mask_full  = &bus.wreq_mask;
    mask_zero  = ~|bus.wreq_mask;
    mask_part  = !mask_full && !mask_zero;
    in_idle    = rst_n && (state_q == ST_IDLE);
    in_rmw     = rst_n && (state_q == ST_RMW);
    wreq_ready = in_idle;
    // Writes win the read port only when they actually need it.
    rreq_ready = in_idle && !(bus.wreq_valid && mask_part);
    wr_acc     = bus.wreq_valid && wreq_ready;
    rd_acc     = bus.rreq_valid && rreq_ready;
  end

  // Drive the memory ports: read for RMW or host, write for full-mask or merge.
  always_comb begin
    merged  = (bus.R0_data & ~bitmask) | (data_q & bitmask);
    r0_en   = (wr_acc && mask_part) || rd_acc;
    r0_addr = (wr_acc && mask_part) ? bus.wreq_addr : bus.rreq_addr;
    w0_en   = in_rmw || (wr_acc && mask_full);
    w0_addr = in_rmw ? addr_q : bus.wreq_addr;
    w0_data = in_rmw ? merged : bus.wreq_data;
  end

  // Next-state, request latching and read-response/bypass bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_acc && mask_part) begin
          state_d = ST_RMW;
          addr_d  = bus.wreq_addr;
          data_d  = bus.wreq_data;
          mask_d  = bus.wreq_mask;
        end
      end
      ST_RMW:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rresp_valid_d = rd_acc;
    // The memory's own read-during-write result is unusable, so a read
    // colliding with a same-cycle full write returns the write data.
    byp_d      = rd_acc && wr_acc && mask_full && (bus.rreq_addr == bus.wreq_addr);
    byp_data_d = byp_d ? bus.wreq_data : byp_data_q;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rresp_valid_q <= 1'b0;
      byp_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rresp_valid_q <= rresp_valid_d;
      byp_q         <= byp_d;
    end
  end

  // Datapath holding registers; contents are only meaningful when qualified.
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    data_q     <= data_d;
    mask_q     <= mask_d;
    byp_data_q <= byp_data_d;
  end

  assign bus.wreq_ready  = wreq_ready;
  assign bus.rreq_ready  = rreq_ready;
  // A response for a read accepted just before reset is suppressed.
  assign bus.rresp_valid = rresp_valid_q && rst_n;
  assign bus.rresp_data  = byp_q ? byp_data_q : bus.R0_data;
  assign bus.R0_en       = r0_en;
  assign bus.R0_addr     = r0_addr;
  assign bus.W0_en       = w0_en;
  assign bus.W0_addr     = w0_addr;
  assign bus.W0_data     = w0_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_rmw_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rmw_merge
// Purpose  : Self-checking bench for mem_rmw_merge with a memory model and a
//            word-level reference of expected memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rmw_merge;
  localparam int DEPTH  = 48;
  localparam int WIDTH  = 64;
  localparam int GRAN   = 8;
  localparam int ADDR_W = 6;
  localparam int MASK_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_rmw_merge_if #(.WIDTH(WIDTH), .GRAN(GRAN), .ADDR_W(ADDR_W), .MASK_W(MASK_W)) bus ();

  mem_rmw_merge #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .GRAN(GRAN), .ADDR_W(ADDR_W), .MASK_W(MASK_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory macro model: synchronous read, full-word write.
  logic [WIDTH-1:0] mem_arr [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] rd_q = '0;
  always @(posedge clk) begin
    if (bus.W0_en) mem_arr[bus.W0_addr] <= bus.W0_data;
    if (bus.R0_en) rd_q <= mem_arr[bus.R0_addr];
  end
  assign bus.R0_data = rd_q;

  // Reference: what each word should hold after all accepted writes.
  logic [WIDTH-1:0] ref_mem [0:(1<<ADDR_W)-1];

  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;
  logic             exp_rv = 1'b0;
  logic [WIDTH-1:0] exp_rdata = '0;
  logic [WIDTH-1:0] last_rdata = '0;
  logic [WIDTH-1:0] last_w0 = '0;

  function automatic logic [WIDTH-1:0] merge_ref(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [MASK_W-1:0] m);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < MASK_W; b++)
      if (m[b]) r[b*GRAN +: GRAN] = new_w[b*GRAN +: GRAN];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Check the response owed from the previous cycle (or its absence).
  task automatic check_resp();
    chk("rresp_valid", 64'(bus.rresp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("rresp_data", bus.rresp_data, exp_rdata);
      last_rdata = bus.rresp_data;
    end
    exp_rv = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.wreq_valid = 1'b0;
    bus.rreq_valid = 1'b0;
    #1;
    check_resp();
  endtask

  // One transaction slot starting in IDLE: optional write and optional read.
  task automatic txn(input logic wv, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                     input logic [MASK_W-1:0] wm, input logic rv, input logic [ADDR_W-1:0] ra);
    logic full, part, exp_rr, racc;
    logic [WIDTH-1:0] mrg;
    @(negedge clk);
    bus.wreq_valid = wv; bus.wreq_addr = wa; bus.wreq_data = wd; bus.wreq_mask = wm;
    bus.rreq_valid = rv; bus.rreq_addr = ra;
    #1;
    check_resp();
    full   = (wm == 8'hFF);
    part   = (wm != 8'hFF) && (wm != 8'h00);
    exp_rr = !(wv && part);
    racc   = rv && exp_rr;
    chk("wreq_ready", 64'(bus.wreq_ready), 64'(1'b1));
    chk("rreq_ready", 64'(bus.rreq_ready), 64'(exp_rr));
    chk("R0_en", 64'(bus.R0_en), 64'((wv && part) || racc));
    if (wv && part)  chk("R0_addr_rmw", 64'(bus.R0_addr), 64'(wa));
    else if (racc)   chk("R0_addr_rd", 64'(bus.R0_addr), 64'(ra));
    chk("W0_en", 64'(bus.W0_en), 64'(wv && full));
    if (wv && full) begin
      chk("W0_addr", 64'(bus.W0_addr), 64'(wa));
      chk("W0_data", bus.W0_data, wd);
      ref_mem[wa] = wd;
    end
    if (racc) begin
      exp_rv    = 1'b1;
      exp_rdata = ref_mem[ra];
    end
    if (wv && part) begin
      @(negedge clk);
      bus.wreq_valid = 1'b0;
      bus.rreq_valid = 1'b1;
      bus.rreq_addr  = ADDR_W'($urandom_range(0, 15));
      #1;
      check_resp();
      mrg = merge_ref(ref_mem[wa], wd, wm);
      chk("rmw_wreq_ready", 64'(bus.wreq_ready), 64'(1'b0));
      chk("rmw_rreq_ready", 64'(bus.rreq_ready), 64'(1'b0));
      chk("rmw_R0_en", 64'(bus.R0_en), 64'(1'b0));
      chk("rmw_W0_en", 64'(bus.W0_en), 64'(1'b1));
      chk("rmw_W0_addr", 64'(bus.W0_addr), 64'(wa));
      chk("rmw_W0_data", bus.W0_data, mrg);
      last_w0 = bus.W0_data;
      ref_mem[wa] = mrg;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic [MASK_W-1:0] m;
    int sel;
    for (int i = 0; i < (1<<ADDR_W); i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    // Reset with requests pending: nothing may be accepted or issued.
    rst_n = 1'b0;
    bus.wreq_valid = 1'b1; bus.wreq_addr = 6'd1; bus.wreq_data = 64'h1; bus.wreq_mask = 8'hFF;
    bus.rreq_valid = 1'b1; bus.rreq_addr = 6'd1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wreq_ready", 64'(bus.wreq_ready), 64'(1'b0));
    chk("rst_rreq_ready", 64'(bus.rreq_ready), 64'(1'b0));
    chk("rst_R0_en", 64'(bus.R0_en), 64'(1'b0));
    chk("rst_W0_en", 64'(bus.W0_en), 64'(1'b0));
    chk("rst_rresp_valid", 64'(bus.rresp_valid), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.wreq_valid = 1'b0; bus.rreq_valid = 1'b0;
    #1;
    check_resp();

    // Full-mask write then host read of the same word.
    txn(1'b1, 6'd5, 64'h1122334455667788, 8'hFF, 1'b0, 6'd0);
    txn(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd5);
    idle();
    chk("t1_readback", last_rdata, 64'h1122334455667788);

    // Partial write over an all-ones word.
    txn(1'b1, 6'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 6'd0);
    txn(1'b1, 6'd3, 64'h0, 8'h0F, 1'b0, 6'd0);
    chk("t2_merge", last_w0, 64'hFFFFFFFF00000000);

    // Back-to-back partial writes to the same word merge cumulatively.
    txn(1'b1, 6'd7, 64'hAA, 8'h01, 1'b0, 6'd0);
    txn(1'b1, 6'd7, 64'hBB00000000000000, 8'h80, 1'b0, 6'd0);
    txn(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd7);
    idle();
    chk("t3_cumulative", last_rdata, 64'hBB000000000000AA);

    // Same-cycle full write and read: bypass on match, memory otherwise.
    txn(1'b1, 6'd10, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 6'd0);
    txn(1'b1, 6'd9, 64'hDEADBEEF, 8'hFF, 1'b1, 6'd9);
    idle();
    chk("t4_bypass", last_rdata, 64'hDEADBEEF);
    txn(1'b1, 6'd9, 64'hCAFEF00D, 8'hFF, 1'b1, 6'd10);
    idle();
    chk("t4_nobypass", last_rdata, 64'h0123456789ABCDEF);

    // Zero-mask write leaves memory untouched.
    txn(1'b1, 6'd2, 64'h5555555555555555, 8'hFF, 1'b0, 6'd0);
    txn(1'b1, 6'd2, 64'hFFFF0000FFFF0000, 8'h00, 1'b0, 6'd0);
    txn(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd2);
    idle();
    chk("t5_zero_mask", last_rdata, 64'h5555555555555555);

    // Reset asserted during RMW drops the pending write.
    txn(1'b1, 6'd4, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 1'b0, 6'd0);
    @(negedge clk);
    bus.wreq_valid = 1'b1; bus.wreq_addr = 6'd4; bus.wreq_data = 64'hFFFFFFFFFFFFFFFF;
    bus.wreq_mask = 8'h3C; bus.rreq_valid = 1'b0;
    #1;
    check_resp();
    chk("t6_accept_R0_en", 64'(bus.R0_en), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    bus.wreq_valid = 1'b0; bus.rreq_valid = 1'b1; bus.rreq_addr = 6'd4;
    #1;
    check_resp();
    chk("t6_rst_W0_en", 64'(bus.W0_en), 64'(1'b0));
    chk("t6_rst_wreq_ready", 64'(bus.wreq_ready), 64'(1'b0));
    chk("t6_rst_R0_en", 64'(bus.R0_en), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.rreq_valid = 1'b0;
    #1;
    check_resp();
    chk("t6_post_wreq_ready", 64'(bus.wreq_ready), 64'(1'b1));
    txn(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd4);
    idle();
    chk("t6_word_kept", last_rdata, 64'h0F0F0F0F0F0F0F0F);

    // Read accepted just before reset yields no response.
    txn(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd5);
    @(negedge clk);
    rst_n = 1'b0;
    bus.rreq_valid = 1'b0;
    #1;
    chk("t7_rresp_suppressed", 64'(bus.rresp_valid), 64'(1'b0));
    exp_rv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_resp();

    // Randomised mix over a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      d   = {$urandom, $urandom};
      sel = int'($urandom_range(0, 9));
      if (sel < 3)       m = 8'hFF;
      else if (sel == 3) m = 8'h00;
      else begin
        m = 8'($urandom);
        if (m == 8'hFF || m == 8'h00) m = 8'h01;
      end
      txn(1'($urandom), ADDR_W'($urandom_range(0, 15)), d, m,
          1'($urandom), ADDR_W'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
